// File: rtl/hdx_wire_xcvr_pkg.sv
// Shared types and constants for the half-duplex wire transceiver.
// HDX_PARITY_EN adds an even-parity bit to both directions.
package hdx_pkg;

  localparam int unsigned DATA_BITS  = 8;
  localparam logic        IDLE_LEVEL = 1'b1;

`ifdef HDX_PARITY_EN
  localparam int unsigned PAR_BITS = 1;
`else
  localparam int unsigned PAR_BITS = 0;
`endif

  typedef enum logic [3:0] {
    IDLE,
    TX_START,
    TX_DATA,
`ifdef HDX_PARITY_EN
    TX_PAR,
    RX_PAR,
`endif
    TX_STOP,
    TURN,
    RX_START,
    RX_DATA,
    RX_STOP
  } state_e;

  function automatic logic even_par(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/hdx_wire_xcvr_sync_2ff.sv
// Two-flop synchronizer for the raw pad level; resets to the idle line level.
module sync_2ff
  import hdx_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= IDLE_LEVEL;
      sync_q <= IDLE_LEVEL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/hdx_wire_xcvr.sv
// Half-duplex single-wire UART transceiver with line turnaround control.
// Define HDX_PARITY_EN for an even-parity bit after the data bits.
module hdx_wire_xcvr
  import hdx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned TURN_CYCLES  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_byte,
  input  logic       tx_en,
  output logic       tx_busy,
  output logic [7:0] rx_byte,
  output logic       rx_rdy,
  output logic       rx_err,
  output logic       pad_i,
  output logic       pad_t,
  input  logic       pad_o
);

  localparam int unsigned BW  = $clog2(CLKS_PER_BIT);
  localparam int unsigned TW  = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
  localparam int unsigned TXW = DATA_BITS + PAR_BITS;

  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] HALF_LAST = BW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] TURN_LAST = TW'(TURN_CYCLES - 1);
  localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);

  state_e                 state_q, state_d;
  logic [BW-1:0]          baud_q, baud_d;
  logic [2:0]             bit_q, bit_d;
  logic [TW-1:0]          turn_q, turn_d;
  logic [TXW-1:0]         tx_sh_q, tx_sh_d;
  logic [DATA_BITS-1:0]   rx_sh_q, rx_sh_d;
  logic [7:0]             rx_byte_q, rx_byte_d;
  logic                   rx_rdy_q, rx_rdy_d;
  logic                   rx_err_q, rx_err_d;
  logic                   pad_s;
  logic                   baud_last;
  logic                   par_ok;

  sync_2ff u_sync (
    .clk_i (clk),
    .rst_i (reset),
    .d_i   (pad_o),
    .q_o   (pad_s)
  );

`ifdef HDX_PARITY_EN
  logic rx_par_err_q, rx_par_err_d;
  assign par_ok = ~rx_par_err_q;
`else
  assign par_ok = 1'b1;
`endif

  assign baud_last = (baud_q == BAUD_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_q     <= '0;
      turn_q    <= '0;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      rx_byte_q <= '0;
      rx_rdy_q  <= 1'b0;
      rx_err_q  <= 1'b0;
`ifdef HDX_PARITY_EN
      rx_par_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      turn_q    <= turn_d;
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      rx_byte_q <= rx_byte_d;
      rx_rdy_q  <= rx_rdy_d;
      rx_err_q  <= rx_err_d;
`ifdef HDX_PARITY_EN
      rx_par_err_q <= rx_par_err_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_last ? '0 : baud_q + 1'b1;
    bit_d     = bit_q;
    turn_d    = turn_q;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    rx_byte_d = rx_byte_q;
    rx_rdy_d  = 1'b0;
    rx_err_d  = 1'b0;
`ifdef HDX_PARITY_EN
    rx_par_err_d = rx_par_err_q;
`endif
    case (state_q)
      IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        turn_d = '0;
        // Transmit wins over a simultaneous falling edge (collision, not received)
        if (tx_en) begin
`ifdef HDX_PARITY_EN
          tx_sh_d = {even_par(tx_byte), tx_byte};
`else
          tx_sh_d = tx_byte;
`endif
          state_d = TX_START;
        end else if (pad_s != IDLE_LEVEL) begin
          state_d = RX_START;
        end
      end
      TX_START: if (baud_last) state_d = TX_DATA;
      TX_DATA: begin
        if (baud_last) begin
          tx_sh_d = tx_sh_q >> 1;
          bit_d   = bit_q + 1'b1;
          if (bit_q == BIT_LAST) begin
`ifdef HDX_PARITY_EN
            state_d = TX_PAR;
`else
            state_d = TX_STOP;
`endif
          end
        end
      end
`ifdef HDX_PARITY_EN
      TX_PAR: if (baud_last) state_d = TX_STOP;
`endif
      TX_STOP: if (baud_last) state_d = TURN;
      TURN: begin
        baud_d = '0;
        turn_d = turn_q + 1'b1;
        if (turn_q == TURN_LAST) begin
          turn_d  = '0;
          state_d = IDLE;
        end
      end
      RX_START: begin
        if (baud_q == HALF_LAST) begin
          baud_d  = '0;
          state_d = pad_s ? IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (baud_last) begin
          rx_sh_d = {pad_s, rx_sh_q[DATA_BITS-1:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == BIT_LAST) begin
`ifdef HDX_PARITY_EN
            state_d = RX_PAR;
`else
            state_d = RX_STOP;
`endif
          end
        end
      end
`ifdef HDX_PARITY_EN
      RX_PAR: begin
        if (baud_last) begin
          rx_par_err_d = pad_s ^ even_par(rx_sh_q);
          state_d      = RX_STOP;
        end
      end
`endif
      RX_STOP: begin
        if (baud_last) begin
          if (pad_s && par_ok) begin
            rx_byte_d = rx_sh_q;
            rx_rdy_d  = 1'b1;
          end else begin
            rx_err_d  = 1'b1;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pad is driven only while a frame is on the wire; everything else releases it
  always_comb begin
    pad_t = 1'b1;
    pad_i = IDLE_LEVEL;
    case (state_q)
      TX_START: begin
        pad_t = 1'b0;
        pad_i = 1'b0;
      end
      TX_DATA: begin
        pad_t = 1'b0;
        pad_i = tx_sh_q[0];
      end
`ifdef HDX_PARITY_EN
      TX_PAR: begin
        pad_t = 1'b0;
        pad_i = tx_sh_q[0];
      end
`endif
      TX_STOP: begin
        pad_t = 1'b0;
        pad_i = IDLE_LEVEL;
      end
      default: ;
    endcase
  end

  assign tx_busy = (state_q != IDLE);
  assign rx_byte = rx_byte_q;
  assign rx_rdy  = rx_rdy_q;
  assign rx_err  = rx_err_q;

endmodule

// File: tb/tb_hdx_wire_xcvr.sv
// Scoreboard bench for hdx_wire_xcvr: wire monitor and far-end model on the shared pad.
module tb_hdx_wire_xcvr;

  localparam int CPB  = 16;
  localparam int TURN = 4;
`ifdef HDX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FRAME = 10 + PB;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tx_byte;
  logic       tx_en;
  logic       tx_busy;
  logic [7:0] rx_byte;
  logic       rx_rdy;
  logic       rx_err;
  logic       pad_i;
  logic       pad_t;
  logic       pad_o;
  logic       far_q;

  always #5 clk = ~clk;

  // Shared wire: DUT drives when pad_t=0, otherwise far end (pull-up when far_q=1)
  assign pad_o = pad_t ? far_q : pad_i;

  hdx_wire_xcvr #(
    .CLKS_PER_BIT (CPB),
    .TURN_CYCLES  (TURN)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .tx_byte (tx_byte),
    .tx_en   (tx_en),
    .tx_busy (tx_busy),
    .rx_byte (rx_byte),
    .rx_rdy  (rx_rdy),
    .rx_err  (rx_err),
    .pad_i   (pad_i),
    .pad_t   (pad_t),
    .pad_o   (pad_o)
  );

  typedef struct packed {
    logic       err;
    logic [7:0] b;
  } rx_exp_t;

  int         compared   = 0;
  int         mismatched = 0;
  logic [7:0] tx_q[$];
  rx_exp_t    rx_q[$];
  logic [7:0] last_good;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Wire-level frame: start 0, data LSB first, optional even parity, stop
  function automatic logic [FRAME-1:0] frame_bits(input logic [7:0] b, input logic stop,
                                                  input logic par_flip);
    logic [FRAME-1:0] f;
    f    = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[1+i] = b[i];
    f[9]       = logic'($countones(b) % 2) ^ par_flip;
    f[FRAME-1] = stop;
    return f;
  endfunction

  task automatic tx_req(input logic [7:0] b, input bit expect_frame);
    tx_byte = b;
    tx_en   = 1'b1;
    if (expect_frame) tx_q.push_back(b);
    @(negedge clk);
    tx_en = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (tx_busy === 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("idle_wait", tx_busy, 0);
  endtask

  task automatic far_send(input logic [7:0] b, input logic stop, input logic par_flip);
    logic [FRAME-1:0] f;
    rx_exp_t          e;
    f     = frame_bits(b, stop, par_flip);
    e.b   = b;
    e.err = !stop || (PB == 1 && par_flip);
    rx_q.push_back(e);
    for (int k = 0; k < FRAME; k++) begin
      far_q = f[k];
      repeat (CPB) @(negedge clk);
    end
    far_q = 1'b1;
  endtask

  // Transmit monitor: captures mid-bit samples of each driven frame
  initial begin : tx_mon
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && pad_t === 1'b0) begin
        logic [FRAME-1:0] seen;
        logic [7:0]       b;
        bit               aborted;
        bit               held;
        seen    = '0;
        aborted = 1'b0;
        held    = 1'b1;
        for (int off = 0; off < FRAME * CPB; off++) begin
          if (reset === 1'b1) begin
            aborted = 1'b1;
            break;
          end
          if (pad_t !== 1'b0) held = 1'b0;
          if (off % CPB == CPB / 2) seen[off/CPB] = pad_i;
          @(negedge clk);
        end
        if (aborted) begin
          while (reset === 1'b1) @(negedge clk);
        end else begin
          check("tx_drive_window", 32'(held), 1);
          check("tx_release", pad_t, 1);
          if (tx_q.size() == 0) begin
            check("tx_unexpected_frame", 1, 0);
          end else begin
            b = tx_q.pop_front();
            check("tx_frame", 32'(seen), 32'(frame_bits(b, 1'b1, 1'b0)));
          end
          repeat (TURN - 1) @(negedge clk);
          check("tx_busy_turn", tx_busy, 1);
          @(negedge clk);
          check("tx_busy_fall", tx_busy, 0);
        end
      end
    end
  end

  // Receive monitor: every rx pulse is matched against the next expected far-end frame
  initial begin : rx_mon
    rx_exp_t e;
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && (rx_rdy === 1'b1 || rx_err === 1'b1)) begin
        check("rx_exclusive", 32'(rx_rdy & rx_err), 0);
        check("rx_idle_after", tx_busy, 0);
        if (rx_q.size() == 0) begin
          check("rx_unexpected_pulse", 1, 0);
        end else begin
          e = rx_q.pop_front();
          check("rx_err_flag", rx_err, 32'(e.err));
          check("rx_rdy_flag", rx_rdy, 32'(!e.err));
          if (!e.err) last_good = e.b;
          check("rx_byte", rx_byte, 32'(last_good));
        end
      end
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    reset     = 1'b1;
    tx_en     = 1'b0;
    tx_byte   = '0;
    far_q     = 1'b1;
    last_good = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_pad_t", pad_t, 1);
    check("rst_pad_i", pad_i, 1);
    check("rst_tx_busy", tx_busy, 0);
    check("rst_rx_byte", rx_byte, 0);
    check("rst_rx_rdy", rx_rdy, 0);
    check("rst_rx_err", rx_err, 0);

    tx_req(8'hA5, 1'b1);
    wait_idle();
    repeat (2) @(negedge clk);

    far_send(8'h3C, 1'b1, 1'b0);
    repeat (30) @(negedge clk);
    far_send(8'h55, 1'b0, 1'b0);
    repeat (30) @(negedge clk);
    wait_idle();

    far_q = 1'b0;
    repeat (5) @(negedge clk);
    far_q = 1'b1;
    repeat (20) @(negedge clk);
    check("glitch_idle", tx_busy, 0);
    tx_req(8'($urandom()), 1'b1);
    wait_idle();
    repeat (2) @(negedge clk);

    tx_req(8'h5A, 1'b1);
    repeat (70) @(negedge clk);
    tx_req(8'hE7, 1'b0);
    n = 0;
    while (pad_t !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("turn_reached", pad_t, 1);
    tx_req(8'hC3, 1'b0);
    wait_idle();
    repeat (200) @(negedge clk);

    tx_req(8'hFF, 1'b0);
    repeat (CPB * 5 + 3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("reset_release_pad", pad_t, 1);
    check("reset_busy", tx_busy, 0);
    repeat (2) @(negedge clk);
    reset     = 1'b0;
    last_good = '0;
    @(negedge clk);
    check("reset_rx_byte", rx_byte, 0);
    tx_req(8'h81, 1'b1);
    wait_idle();
    repeat (2) @(negedge clk);

`ifdef HDX_PARITY_EN
    far_send(8'h03, 1'b1, 1'b1);
    repeat (30) @(negedge clk);
`endif

    for (int i = 0; i < 14; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        tx_req(8'($urandom()), 1'b1);
        wait_idle();
      end else begin
        far_send(8'($urandom()), logic'($urandom_range(0, 4) != 0),
                 logic'(PB == 1 && $urandom_range(0, 3) == 0));
      end
      repeat (30) @(negedge clk);
    end

    repeat (50) @(negedge clk);
    check("tx_queue_drained", tx_q.size(), 0);
    check("rx_queue_drained", rx_q.size(), 0);
    check("rx_byte_final", rx_byte, 32'(last_good));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
